// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide engine for the multicycle datapath.
// Multiply uses shift-add steps and divide uses restoring division. Both run
// on operand magnitudes, and the signs are fixed up in a final cycle.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   MULTcontrol           start signed multiply (pulse, sampled in IDLE)
//   DIVcontrol            start signed divide (pulse, sampled in IDLE)
//   A, B                  rs / rt operands
//   HI, LO                product halves, or remainder / quotient
//   Busy                  operation in progress
//   Done                  one-cycle pulse when HI/LO were just written
//   Div0                  one-cycle pulse on a divide request with B == 0
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MULTcontrol,
  input  logic             DIVcontrol,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             Div0
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   dvs;       // |A| for multiply, |B| for divide
  logic [2*WIDTH-1:0] acc;       // product, or {remainder, dividend/quotient}
  logic               is_div;
  logic               neg_lo;    // negate the product or the quotient
  logic               neg_hi;    // negate the remainder (sign of dividend)

  logic               last;
  logic               div_ok;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_add;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  // Two's-complement magnitude; the most negative value maps to its unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign div_ok = (B != {WIDTH{1'b0}});

  // Shift-add step: add the multiplicand when the current multiplier bit is set, then shift right.
  always_comb begin
    mul_add  = acc[0] ? dvs : {WIDTH{1'b0}};
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Restoring step: shift the next dividend bit into the remainder, then trial-subtract.
  // The quotient bit is set when no borrow occurs.
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, dvs};
    div_next  = {(div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                 acc[WIDTH-2:0], ~div_trial[WIDTH]};
  end

  // Sign correction applied in FIN.
  always_comb begin
    prod_signed = neg_lo ? -acc : acc;
    if (is_div) begin
      fin_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fin_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      fin_lo = prod_signed[WIDTH-1:0];
      fin_hi = prod_signed[2*WIDTH-1:WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; MULTcontrol has priority over DIVcontrol.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (MULTcontrol)                state_nxt = MUL;
        else if (DIVcontrol && div_ok)  state_nxt = DIV;
      end
      MUL:     if (last) state_nxt = FIN;
      DIV:     if (last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      dvs    <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Div0   <= 1'b0;
    end else begin
      Done <= 1'b0;
      Div0 <= 1'b0;
      case (state)
        IDLE: begin
          if (MULTcontrol) begin
            dvs    <= mag(A);
            acc    <= {{WIDTH{1'b0}}, mag(B)};
            is_div <= 1'b0;
            neg_lo <= A[WIDTH-1] ^ B[WIDTH-1];
            neg_hi <= 1'b0;
            cnt    <= '0;
            Busy   <= 1'b1;
          end else if (DIVcontrol) begin
            if (div_ok) begin
              dvs    <= mag(B);
              acc    <= {{WIDTH{1'b0}}, mag(A)};
              is_div <= 1'b1;
              neg_lo <= A[WIDTH-1] ^ B[WIDTH-1];
              neg_hi <= A[WIDTH-1];
              cnt    <= '0;
              Busy   <= 1'b1;
            end else begin
              Div0 <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + CNT_W'(1);
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + CNT_W'(1);
        end
        FIN: begin
          HI   <= fin_hi;
          LO   <= fin_lo;
          Done <= 1'b1;
          Busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
